// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encoding,
// prefix scan codes and the frame parity helper.
package ps2_kbd_rx_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  localparam logic [7:0] ScanE0 = 8'hE0;
  localparam logic [7:0] ScanF0 = 8'hF0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Receiver output bundle: raw frame bytes plus decoded key events.
interface ps2_kbd_rx_if;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_err;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;
  logic       key_strobe;

  modport master (
    output rx_byte, rx_strobe, rx_err, key_code, key_pressed, key_extended, key_strobe
  );
  modport slave (
    input rx_byte, rx_strobe, rx_err, key_code, key_pressed, key_extended, key_strobe
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// 11-bit PS/2 frame receiver: synchronizers, ps2_clk glitch filter, frame FSM
// and an inactivity timeout that abandons partial frames.
module ps2_frame_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int unsigned FILTER  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          fall;

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;

  // A new level is accepted on the FILTER-th consecutive differing sample.
  assign fall = clk_filt_q & ~clk_sync_q[1] & (filt_cnt_q == FW'(FILTER - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER - 1)) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    rx_byte_d = rx_byte_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (state_q == StIdle || fall) ? '0 : tmo_q + 1'b1;

    if (fall) begin
      case (state_q)
        StIdle: begin
          if (!data_sync_q[1]) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        StData: begin
          shift_d   = {data_sync_q[1], shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = data_sync_q[1];
          state_d = StStop;
        end
        default: begin
          state_d = StIdle;
          if (data_sync_q[1] && parity_ok(shift_q, par_q)) begin
            rx_byte_d = shift_q;
            strobe_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != StIdle && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      rx_byte_q <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      rx_byte_q <= rx_byte_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_strobe = strobe_q;
  assign rx_err    = err_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame receiver plus E0/F0 prefix decoder producing
// make/break key events.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int unsigned FILTER  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_kbd_rx_if.master    kbd
);

  logic [7:0] rx_byte;
  logic       rx_strobe, rx_err;
  logic       ext_q, brk_q;
  logic [7:0] key_code_q;
  logic       key_pressed_q, key_ext_q, key_strobe_q;

  ps2_frame_rx #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT)
  ) u_frame (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_strobe(rx_strobe),
    .rx_err   (rx_err)
  );

  // A bad frame may have been part of a prefixed sequence, so drop any prefix.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_code_q    <= '0;
      key_pressed_q <= 1'b0;
      key_ext_q     <= 1'b0;
      key_strobe_q  <= 1'b0;
    end else begin
      key_strobe_q <= 1'b0;
      if (rx_err) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (rx_strobe) begin
        if (rx_byte == ScanE0) begin
          ext_q <= 1'b1;
        end else if (rx_byte == ScanF0) begin
          brk_q <= 1'b1;
        end else begin
          key_code_q    <= rx_byte;
          key_ext_q     <= ext_q;
          key_pressed_q <= ~brk_q;
          key_strobe_q  <= 1'b1;
          ext_q         <= 1'b0;
          brk_q         <= 1'b0;
        end
      end
    end
  end

  assign kbd.rx_byte      = rx_byte;
  assign kbd.rx_strobe    = rx_strobe;
  assign kbd.rx_err       = rx_err;
  assign kbd.key_code     = key_code_q;
  assign kbd.key_pressed  = key_pressed_q;
  assign kbd.key_extended = key_ext_q;
  assign kbd.key_strobe   = key_strobe_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: drives PS/2 frames and scoreboards the
// expected byte, error and key events against the DUT outputs.
module tb_ps2_kbd_rx;
  import ps2_kbd_rx_pkg::*;

  localparam int unsigned Filter  = 4;
  localparam int unsigned Timeout = 1024;
  localparam int          Half    = 20;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } rx_exp_t;

  typedef struct packed {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } key_exp_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_kbd_rx_if kbd_if ();

  ps2_kbd_rx #(
    .FILTER (Filter),
    .TIMEOUT(Timeout)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kbd     (kbd_if)
  );

  always #5 clk_sys = ~clk_sys;

  int       n_checks = 0;
  int       n_errors = 0;
  rx_exp_t  exp_rx[$];
  key_exp_t exp_key[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_rx.push_back('{is_err: 1'b0, data: b});
  endtask

  task automatic expect_err();
    exp_rx.push_back('{is_err: 1'b1, data: 8'h00});
  endtask

  task automatic expect_key(input logic [7:0] code, input logic pressed, input logic ext);
    exp_key.push_back('{code: code, pressed: pressed, ext: ext});
  endtask

  // Device-side frame: data changes while the clock is high. Optional
  // single-cycle glitches land mid-phase, well away from real edges.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits,
                            input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc(Half);
      ps2_clk = 1'b0;
      if (glitch) begin
        wait_cyc(Half / 2);
        ps2_clk = 1'b1;
        wait_cyc(1);
        ps2_clk = 1'b0;
        wait_cyc(Half - Half / 2 - 1);
      end else begin
        wait_cyc(Half);
      end
      ps2_clk = 1'b1;
      if (glitch) begin
        wait_cyc(Half / 2);
        ps2_clk = 1'b0;
        wait_cyc(1);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    wait_cyc(Half);
  endtask

  initial begin
    fork
      begin : monitor
        logic     prev_rx_strobe = 1'b0;
        logic     prev_rx_err    = 1'b0;
        logic     prev_key       = 1'b0;
        logic [7:0] last_good    = 8'h00;
        rx_exp_t  er;
        key_exp_t ek;
        forever begin
          @(negedge clk_sys);
          if (reset) last_good = 8'h00;
          if (kbd_if.rx_strobe) check_eq("rx_strobe_width", 32'(prev_rx_strobe), 32'd0);
          if (kbd_if.rx_err) check_eq("rx_err_width", 32'(prev_rx_err), 32'd0);
          if (kbd_if.rx_strobe || kbd_if.rx_err) begin
            check_eq("rx_event_expected", 32'(exp_rx.size() != 0), 32'd1);
            if (exp_rx.size() != 0) begin
              er = exp_rx.pop_front();
              check_eq("rx_kind_err", 32'(kbd_if.rx_err), 32'(er.is_err));
              if (!er.is_err) begin
                check_eq("rx_byte", 32'(kbd_if.rx_byte), 32'(er.data));
                last_good = er.data;
              end else begin
                check_eq("rx_byte_hold", 32'(kbd_if.rx_byte), 32'(last_good));
              end
            end
          end
          if (kbd_if.key_strobe) begin
            check_eq("key_strobe_width", 32'(prev_key), 32'd0);
            check_eq("key_latency", 32'(prev_rx_strobe), 32'd1);
            check_eq("key_event_expected", 32'(exp_key.size() != 0), 32'd1);
            if (exp_key.size() != 0) begin
              ek = exp_key.pop_front();
              check_eq("key_code", 32'(kbd_if.key_code), 32'(ek.code));
              check_eq("key_pressed", 32'(kbd_if.key_pressed), 32'(ek.pressed));
              check_eq("key_extended", 32'(kbd_if.key_extended), 32'(ek.ext));
            end
          end
          prev_rx_strobe = kbd_if.rx_strobe;
          prev_rx_err    = kbd_if.rx_err;
          prev_key       = kbd_if.key_strobe;
        end
      end
    join_none

    wait_cyc(5);
    check_eq("reset_rx_byte", 32'(kbd_if.rx_byte), 32'd0);
    check_eq("reset_rx_strobe", 32'(kbd_if.rx_strobe), 32'd0);
    check_eq("reset_rx_err", 32'(kbd_if.rx_err), 32'd0);
    check_eq("reset_key_code", 32'(kbd_if.key_code), 32'd0);
    check_eq("reset_key_pressed", 32'(kbd_if.key_pressed), 32'd0);
    check_eq("reset_key_extended", 32'(kbd_if.key_extended), 32'd0);
    check_eq("reset_key_strobe", 32'(kbd_if.key_strobe), 32'd0);
    reset = 1'b0;
    wait_cyc(10);

    // Plain make code.
    expect_byte(8'h1C); expect_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);

    // Break.
    expect_byte(8'hF0); expect_byte(8'h1C); expect_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);

    // Extended break.
    expect_byte(8'hE0); expect_byte(8'hF0); expect_byte(8'h75);
    expect_key(8'h75, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    send_frame(8'h75, 1'b0, 11, 1'b0);

    // Parity error after an E0 prefix must drop the prefix.
    expect_byte(8'hE0); expect_err();
    expect_byte(8'h1B); expect_key(8'h1B, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    send_frame(8'h1B, 1'b0, 11, 1'b0);

    // Timeout: start bit plus five data bits, then silence.
    expect_err();
    send_frame(8'h29, 1'b0, 6, 1'b0);
    wait_cyc(Timeout + 10);
    check_eq("timeout_idle", 32'(dut.u_frame.state_q), 32'(StIdle));
    check_eq("timeout_rx_queue", 32'(exp_rx.size()), 32'd0);
    expect_byte(8'h29); expect_key(8'h29, 1'b1, 1'b0);
    send_frame(8'h29, 1'b0, 11, 1'b0);

    // Glitchy clock must not add bits.
    expect_byte(8'h34); expect_key(8'h34, 1'b1, 1'b0);
    send_frame(8'h34, 1'b0, 11, 1'b1);

    // Reset mid-frame discards the frame silently.
    send_frame(8'h66, 1'b0, 5, 1'b0);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    check_eq("midreset_rx_byte", 32'(kbd_if.rx_byte), 32'd0);
    check_eq("midreset_key_code", 32'(kbd_if.key_code), 32'd0);
    check_eq("midreset_key_pressed", 32'(kbd_if.key_pressed), 32'd0);
    wait_cyc(Timeout + 10);
    expect_byte(8'h5A); expect_key(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 11, 1'b0);

    wait_cyc(200);
    check_eq("final_rx_queue", 32'(exp_rx.size()), 32'd0);
    check_eq("final_key_queue", 32'(exp_key.size()), 32'd0);
    check_eq("final_key_code", 32'(kbd_if.key_code), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
